// File: rtl/countdown_ctrl_pkg.sv
// Shared ALU definitions: countdown FSM encoding and default counter width.
package countdown_ctrl_pkg;

  localparam int CD_WIDTH = 6;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // State entered when a start is accepted with the given load value.
  function automatic logic [1:0] accept_state(input logic nonzero);
    return nonzero ? ST_RUN : ST_DONE;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Start/busy/done handshake between multiply/divide control and the
// countdown sequencer.
interface countdown_ctrl_if
  import countdown_ctrl_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] load_value;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             last;
  logic             done;

  modport master (
    output start, load_value, hold, abort,
    input  count, busy, last, done
  );

  modport slave (
    input  start, load_value, hold, abort,
    output count, busy, last, done
  );

endinterface

// File: rtl/countdown_ctrl_dcount_reg.sv
// Down-count register: clear > load > decrement, saturating at zero.
module dcount_reg
  import countdown_ctrl_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (ld)
      q <= d;
    else if (dec && (q != '0))
      q <= q - WIDTH'(1);
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Loadable countdown sequencer: IDLE -> RUN -> DONE with hold/abort,
// one-cycle done pulse and back-to-back restart from DONE.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  countdown_ctrl_if.slave   bus
);

  logic [1:0]       state;
  logic [1:0]       nxt;
  logic             clr;
  logic             ld;
  logic             dec;
  logic [WIDTH-1:0] cnt;
  logic             at_one;

  assign at_one = (cnt == WIDTH'(1));

  always_comb begin
    nxt = state;
    clr = reset;
    ld  = 1'b0;
    dec = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            ld  = 1'b1;
            nxt = accept_state(bus.load_value != '0);
          end else begin
            nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          // abort outranks hold; start is ignored here
          if (bus.abort) begin
            clr = 1'b1;
            nxt = ST_IDLE;
          end else if (!bus.hold) begin
            dec = 1'b1;
            if (at_one)
              nxt = ST_DONE;
          end
        end
        default: begin
          clr = 1'b1;
          nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= nxt;
  end

  dcount_reg #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk (clk),
    .clr (clr),
    .ld  (ld),
    .d   (bus.load_value),
    .dec (dec),
    .q   (cnt)
  );

  assign bus.count = cnt;
  assign bus.busy  = (state == ST_RUN);
  assign bus.done  = (state == ST_DONE);
  assign bus.last  = (state == ST_RUN) && at_one && !bus.hold;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl; observes {count,busy,last,done}.
module tb_countdown_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edges = 0;
  logic [8:0] obs;
  logic [8:0] exp;

  countdown_ctrl_if #(.WIDTH(6)) bus ();

  countdown_ctrl #(
    .WIDTH (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  function automatic logic [8:0] pk(input logic [5:0] c,
                                    input logic b,
                                    input logic l,
                                    input logic d);
    return {c, b, l, d};
  endfunction

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.load_value = '0;
    bus.hold       = 1'b0;
    bus.abort      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs, exp);
    end
    bus.hold  = 1'b1;
    bus.abort = 1'b1;
    tick();
    idle_inputs();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL idle_ignore: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_basic();
    bus.start      = 1'b1;
    bus.load_value = 6'd5;
    tick();
    edges = 0;
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      obs = {bus.count, bus.busy, bus.last, bus.done};
      exp = pk(6'(5 - k), 1'b1, (k == 4), 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL basic_run k=%0d: got %h want %h", k, obs, exp);
      end
      tick();
    end
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== exp || edges != 5) begin
      n_bad++;
      $display("FAIL basic_done: got %h@%0d want %h@5", obs, edges, exp);
    end
    tick();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL basic_idle: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_zero();
    bus.start      = 1'b1;
    bus.load_value = 6'd0;
    tick();
    idle_inputs();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL zero_done: got %h want %h", obs, exp);
    end
    tick();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL zero_idle: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_hold();
    bus.start      = 1'b1;
    bus.load_value = 6'd4;
    tick();
    edges = 0;
    idle_inputs();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.hold = 1'b1;
      obs = {bus.count, bus.busy, bus.last, bus.done};
      exp = pk(6'd2, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL hold_at2 i=%0d: got %h want %h", i, obs, exp);
      end
      tick();
    end
    bus.hold = 1'b0;
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd2, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL hold_release: got %h want %h", obs, exp);
    end
    tick();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL hold_last: got %h want %h", obs, exp);
    end
    bus.hold = 1'b1;
    #1;
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL hold_at1_last: got %h want %h", obs, exp);
    end
    tick();
    bus.hold = 1'b0;
    tick();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== exp || edges != 8) begin
      n_bad++;
      $display("FAIL hold_done: got %h@%0d want %h@8", obs, edges, exp);
    end
    tick();
  endtask

  task automatic test_abort();
    bus.start      = 1'b1;
    bus.load_value = 6'd5;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start      = 1'b1;
    bus.load_value = 6'd9;
    tick();
    idle_inputs();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd3, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL start_ignored: got %h want %h", obs, exp);
    end
    bus.abort = 1'b1;
    bus.hold  = 1'b1;
    tick();
    idle_inputs();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL abort: got %h want %h", obs, exp);
    end
    tick();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL abort_no_done: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    bus.start      = 1'b1;
    bus.load_value = 6'd63;
    tick();
    idle_inputs();
    for (int k = 0; k < 63; k++) begin
      obs = {bus.count, bus.busy, bus.last, bus.done};
      exp = pk(6'(63 - k), 1'b1, (k == 62), 1'b0);
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL max_run k=%0d: got %h want %h", k, obs, exp);
      end
      tick();
    end
    n_cmp++;
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL max_done: got %h want %h", obs, exp);
    end
    if (bus.done === 1'b1) pulses++;
    bus.start      = 1'b1;
    bus.load_value = 6'd2;
    bus.abort      = 1'b1;
    bus.hold       = 1'b1;
    tick();
    idle_inputs();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd2, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL b2b_restart: got %h want %h", obs, exp);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_mid();
    bus.start      = 1'b1;
    bus.load_value = 6'd12;
    tick();
    idle_inputs();
    tick();
    tick();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd10, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL pre_reset: got %h want %h", obs, exp);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_run: got %h want %h", obs, exp);
    end
    tick();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_no_done: got %h want %h", obs, exp);
    end
    bus.start      = 1'b1;
    bus.load_value = 6'd1;
    tick();
    idle_inputs();
    tick();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL n1_done: got %h want %h", obs, exp);
    end
    reset          = 1'b1;
    bus.start      = 1'b1;
    bus.load_value = 6'd7;
    tick();
    reset = 1'b0;
    idle_inputs();
    obs = {bus.count, bus.busy, bus.last, bus.done};
    exp = pk(6'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_done: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_zero();
    test_hold();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
